// File: rtl/cmac_column_param.sv
// Column of N_PE chained multiply-accumulate stages with per-stage timing-error
// tolerance: errored products are either deferred one stage or dropped.
module cmac_column_param #(
  parameter int unsigned N_PE   = 4,
  parameter int unsigned A_W    = 8,
  parameter int unsigned W_W    = 8,
  parameter int unsigned PSUM_W = 24,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  weight_load,
  input  logic [N_PE*W_W-1:0]   weight_in,
  input  logic                  in_valid,
  input  logic [N_PE*A_W-1:0]   act_in,
  input  logic [PSUM_W-1:0]     psum_in,
  input  logic [N_PE-1:0]       err_flag,
  input  logic                  comp_en,
  input  logic                  err_cnt_clr,
  output logic                  out_valid,
  output logic [PSUM_W-1:0]     psum_out,
  output logic                  out_err,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int unsigned PROD_W = A_W + W_W;

  logic [N_PE-1:0][W_W-1:0]    w_q;
  logic [N_PE-1:0][A_W-1:0]    stage_act;
  logic [N_PE-1:0][PSUM_W-1:0] psum_q;
  logic [N_PE-1:0][PSUM_W-1:0] eprod_q;
  logic [N_PE-1:0]             valid_q;
  logic [N_PE-1:0]             err_q;
  logic [N_PE-1:0]             hit;

  // Shared weight registers; in-flight tokens see a reload in their later stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else if (weight_load) begin
      w_q <= weight_in;
    end
  end

  for (genvar k = 0; k < N_PE; k++) begin : g_stage
    logic [PSUM_W-1:0] psum_prev;
    logic [PSUM_W-1:0] eprod_prev;
    logic              valid_prev;
    logic              err_prev;
    logic [PROD_W-1:0] prod;
    logic [PSUM_W-1:0] base;
    logic [PSUM_W-1:0] psum_r;
    logic [PSUM_W-1:0] eprod_r;
    logic              valid_r;
    logic              err_r;

    if (k == 0) begin : g_first
      assign psum_prev    = psum_in;
      assign eprod_prev   = '0;
      assign valid_prev   = in_valid;
      assign err_prev     = 1'b0;
      assign stage_act[k] = act_in[k*A_W +: A_W];
    end else begin : g_next
      logic [A_W-1:0] dly [k];

      assign psum_prev  = psum_q[k-1];
      assign eprod_prev = eprod_q[k-1];
      assign valid_prev = valid_q[k-1];
      assign err_prev   = err_q[k-1];

      // k-deep delay keeps this stage's activation aligned with its token
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < k; i++) dly[i] <= '0;
        end else begin
          dly[0] <= act_in[k*A_W +: A_W];
          for (int i = 1; i < k; i++) dly[i] <= dly[i-1];
        end
      end

      assign stage_act[k] = dly[k-1];
    end

    assign prod   = PROD_W'(w_q[k]) * PROD_W'(stage_act[k]);
    assign base   = psum_prev + eprod_prev;
    assign hit[k] = valid_prev & err_flag[k];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        psum_r  <= '0;
        eprod_r <= '0;
        valid_r <= 1'b0;
        err_r   <= 1'b0;
      end else begin
        valid_r <= valid_prev;
        if (valid_prev) begin
          err_r <= err_prev | err_flag[k];
          if (!err_flag[k]) begin
            psum_r  <= base + PSUM_W'(prod);
            eprod_r <= '0;
          end else begin
            psum_r  <= base;
            eprod_r <= comp_en ? PSUM_W'(prod) : '0;
          end
        end
      end
    end

    assign psum_q[k]  = psum_r;
    assign eprod_q[k] = eprod_r;
    assign valid_q[k] = valid_r;
    assign err_q[k]   = err_r;
  end

  // Correction register folds in a product deferred by the last stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      psum_out  <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= valid_q[N_PE-1];
      if (valid_q[N_PE-1]) begin
        psum_out <= psum_q[N_PE-1] + eprod_q[N_PE-1];
        out_err  <= err_q[N_PE-1];
      end
    end
  end

  // Saturating error-event counter; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if ((|hit) && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cmac_column_param.sv
// Scoreboard bench for cmac_column_param (N_PE=2, CNT_W=2): directed vectors
// plus randomized schedules checked against a token-level arithmetic model.
module tb_cmac_column_param;

  localparam int N      = 2;
  localparam int MAXC   = 256;
  localparam int PSUM_W = 24;

  logic              clk;
  logic              rst_n;
  logic              weight_load;
  logic [15:0]       weight_in;
  logic              in_valid;
  logic [15:0]       act_in;
  logic [23:0]       psum_in;
  logic [1:0]        err_flag;
  logic              comp_en;
  logic              err_cnt_clr;
  logic              out_valid;
  logic [23:0]       psum_out;
  logic              out_err;
  logic [1:0]        err_cnt;

  cmac_column_param #(.N_PE(N), .A_W(8), .W_W(8), .PSUM_W(PSUM_W), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .weight_load(weight_load), .weight_in(weight_in),
    .in_valid(in_valid), .act_in(act_in), .psum_in(psum_in), .err_flag(err_flag),
    .comp_en(comp_en), .err_cnt_clr(err_cnt_clr), .out_valid(out_valid),
    .psum_out(psum_out), .out_err(out_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [23:0] psum;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cnt_q[$];

  // Per-cycle schedule; index = cycle offset within one play() call
  logic        s_valid [MAXC];
  logic [15:0] s_act   [MAXC];
  logic [23:0] s_psum  [MAXC];
  logic [1:0]  s_err   [MAXC];
  logic        s_comp  [MAXC];
  logic        s_wl    [MAXC];
  logic [15:0] s_win   [MAXC];
  logic        s_clr   [MAXC];
  logic [23:0] d_psum  [MAXC];
  logic        d_err   [MAXC];
  logic [15:0] cur_w = 16'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
  endtask

  // Monitor: pop one expectation per presented result, one count per edge
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("psum_out", 32'(psum_out), 32'(e.psum));
        chk("out_err", 32'(out_err), 32'(e.err));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (cnt_q.size() > 0) chk("err_cnt_trace", 32'(err_cnt), 32'(cnt_q.pop_front()));
  end

  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++) begin
      s_valid[c] = 1'b0; s_act[c] = '0; s_psum[c] = '0; s_err[c] = '0;
      s_comp[c] = 1'b0; s_wl[c] = 1'b0; s_win[c] = '0; s_clr[c] = 1'b0;
      d_psum[c] = '0; d_err[c] = 1'b0;
    end
  endtask

  // Plays n scheduled cycles plus drain; expectations come from the model or d_*
  task automatic play(input int n, input bit use_model, input bit chk_cnt);
    logic [15:0] w_at [MAXC];
    logic [15:0] w;
    int total;
    int base;
    int cm;
    total = n + N + 3;
    w = cur_w;
    for (int c = 0; c < total; c++) begin
      w_at[c] = w;
      if (s_wl[c]) w = s_win[c];
    end
    cur_w = w;
    @(negedge clk);
    base = cyc;
    for (int t = 0; t < n; t++) begin
      if (s_valid[t]) begin
        exp_t e;
        logic [23:0] acc;
        logic any;
        acc = s_psum[t];
        any = 1'b0;
        if (use_model) begin
          // Every product lands once unless errored with compensation off
          for (int k = 0; k < N; k++) begin
            logic [15:0] wv, av;
            logic [15:0] ww;
            int p;
            ww = w_at[t+k];
            wv = 16'(ww >> (8*k)) & 16'h00FF;
            av = 16'(s_act[t] >> (8*k)) & 16'h00FF;
            p = int'(wv) * int'(av);
            if (!s_err[t+k][k] || s_comp[t+k]) acc = acc + 24'(p);
            any = any | s_err[t+k][k];
          end
          e.psum = acc;
          e.err  = any;
        end else begin
          e.psum = d_psum[t];
          e.err  = d_err[t];
        end
        e.cyc = base + t + 1 + N;
        exp_q.push_back(e);
      end
    end
    if (chk_cnt) begin
      cm = 0;
      for (int c = 0; c < total; c++) begin
        bit ev;
        ev = 1'b0;
        for (int k = 0; k < N; k++)
          if (c - k >= 0 && c - k < n && s_valid[c-k] && s_err[c][k]) ev = 1'b1;
        if (s_clr[c]) cm = 0;
        else if (ev && cm < 3) cm++;
        cnt_q.push_back(cm);
      end
    end
    for (int c = 0; c < total; c++) begin
      in_valid    = s_valid[c];
      act_in      = s_act[c];
      psum_in     = s_psum[c];
      err_flag    = s_err[c];
      comp_en     = s_comp[c];
      weight_load = s_wl[c];
      weight_in   = s_win[c];
      err_cnt_clr = s_clr[c];
      @(negedge clk);
    end
    chk("exp_queue_drained", 32'(exp_q.size()), 32'(0));
    chk("cnt_queue_drained", 32'(cnt_q.size()), 32'(0));
  endtask

  task automatic one_token(input int t, input logic [23:0] ps, input logic [15:0] act,
                           input logic [23:0] want, input logic werr);
    s_valid[t] = 1'b1; s_psum[t] = ps; s_act[t] = act;
    d_psum[t] = want; d_err[t] = werr;
  endtask

  initial begin
    rst_n = 1'b0; weight_load = 1'b0; weight_in = '0; in_valid = 1'b0; act_in = '0;
    psum_in = '0; err_flag = '0; comp_en = 1'b0; err_cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_psum_out", 32'(psum_out), 32'(0));
    chk("rst_out_err", 32'(out_err), 32'(0));
    chk("rst_err_cnt", 32'(err_cnt), 32'(0));
    rst_n = 1'b1;

    clear_sched(); s_wl[0] = 1'b1; s_win[0] = 16'h3010; s_clr[0] = 1'b1;
    play(1, 0, 0);

    // Nominal
    clear_sched(); one_token(0, 24'h004000, 16'h0402, 24'h0040E0, 1'b0);
    play(1, 0, 0);
    chk("nominal_err_cnt", 32'(err_cnt), 32'(0));

    // Stage-0 error compensated
    clear_sched(); s_clr[0] = 1'b1; one_token(1, 24'h004000, 16'h0402, 24'h0040E0, 1'b1);
    s_err[1] = 2'b01; s_comp[1] = 1'b1;
    play(2, 0, 0);
    chk("comp_s0_err_cnt", 32'(err_cnt), 32'(1));

    // Last-stage error compensated in correction register
    clear_sched(); s_clr[0] = 1'b1; one_token(1, 24'h004000, 16'h0402, 24'h0040E0, 1'b1);
    s_err[2] = 2'b10; s_comp[2] = 1'b1;
    play(2, 0, 0);
    chk("comp_s1_err_cnt", 32'(err_cnt), 32'(1));

    // Last-stage error dropped
    clear_sched(); s_clr[0] = 1'b1; one_token(1, 24'h004000, 16'h0402, 24'h004020, 1'b1);
    s_err[2] = 2'b10; s_comp[2] = 1'b0;
    play(2, 0, 0);
    chk("drop_err_cnt", 32'(err_cnt), 32'(1));

    // Wrap and back-to-back
    clear_sched();
    one_token(0, 24'hFFFFFF, 16'h0402, 24'h0000DF, 1'b0);
    one_token(1, 24'h004000, 16'h0402, 24'h0040E0, 1'b0);
    one_token(2, 24'h008000, 16'h0402, 24'h0080E0, 1'b0);
    play(3, 0, 0);

    // Weight reload coincident with token
    clear_sched(); s_wl[0] = 1'b1; s_win[0] = 16'h4020;
    one_token(0, 24'h004000, 16'h0603, 24'h0041B0, 1'b0);
    play(1, 0, 0);

    // Counter saturation after five events
    clear_sched(); s_clr[0] = 1'b1; s_wl[0] = 1'b1; s_win[0] = 16'h3010;
    for (int t = 1; t <= 5; t++) begin
      one_token(t, 24'h004000, 16'h0402, 24'h0040E0, 1'b1);
      s_err[t] = 2'b01; s_comp[t] = 1'b1;
    end
    play(6, 0, 0);
    chk("sat_err_cnt", 32'(err_cnt), 32'(3));

    // Clear coincident with error event
    clear_sched(); s_clr[0] = 1'b1; s_err[0] = 2'b01; s_comp[0] = 1'b1;
    one_token(0, 24'h004000, 16'h0402, 24'h0040E0, 1'b1);
    play(1, 0, 0);
    chk("clr_wins_err_cnt", 32'(err_cnt), 32'(0));

    // Randomized schedules against the model
    for (int r = 0; r < 2; r++) begin
      clear_sched();
      for (int c = 0; c < 200; c++) begin
        s_valid[c] = ($urandom_range(0, 3) != 0);
        s_act[c]   = 16'($urandom);
        s_psum[c]  = 24'($urandom);
        s_err[c][0] = ($urandom_range(0, 3) == 0);
        s_err[c][1] = ($urandom_range(0, 3) == 0);
        s_comp[c]  = 1'($urandom_range(0, 1));
        s_wl[c]    = ($urandom_range(0, 15) == 0);
        s_win[c]   = 16'($urandom);
        s_clr[c]   = ($urandom_range(0, 7) == 0);
      end
      s_clr[0] = 1'b1;
      play(200, 1, 1);
    end

    // Reset with two tokens in flight
    @(negedge clk);
    weight_load = 1'b1; weight_in = 16'h3010;
    @(negedge clk);
    weight_load = 1'b0;
    in_valid = 1'b1; act_in = 16'h0402; psum_in = 24'h004000; err_flag = 2'b01; comp_en = 1'b1;
    err_cnt_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0; err_flag = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("async_rst_err_cnt", 32'(err_cnt), 32'(0));
    chk("async_rst_out_valid", 32'(out_valid), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(out_valid), 32'(0));
      chk("post_rst_err_cnt", 32'(err_cnt), 32'(0));
    end
    cur_w = 16'h0;

    // First token after reset, normal latency
    clear_sched(); s_wl[0] = 1'b1; s_win[0] = 16'h3010;
    one_token(1, 24'h004000, 16'h0402, 24'h0040E0, 1'b0);
    play(2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
